fsm_write_data: RTL
===================

Name: fsm_write_data

Overview:
- Game-logic-side writer for the shared game-state BRAM; port B of that BRAM is read by the display path.
- On an update request, snapshots the current game variables and writes them as a fixed block of 16-bit words through BRAM port A, one word per clock.
- Lets the display path always fetch a coherent, fixed-layout record.

Parameters:
- BASE_ADDR, 16'h0000, port-A address of word 0 of the record.
- REC_WORDS, 7, words written per record. Becomes 8 when CHECKSUM_EN is defined; this is derived internally and is not user-set.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- update  input  1  single-cycle request to write a new record.
- game_state  input  2  current game state.
- ball_x  input  10  ball X position.
- ball_y  input  10  ball Y position.
- paddle1_y  input  10  paddle 1 Y position.
- paddle2_y  input  10  paddle 2 Y position.
- player_1_score  input  7  player 1 binary score.
- player_2_score  input  7  player 2 binary score.
- addr_a  output  16  BRAM port-A address.
- data_a  output  16  BRAM port-A write data.
- we_a  output  1  BRAM port-A write enable.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the last word of a record is written.

Behaviour:
- Reset: state=IDLE, addr_a=BASE_ADDR, data_a=0, we_a=0, busy=0, done=0, pending=0, word counter=0.
- Record layout (address BASE_ADDR+k, all fields zero-extended to 16 bits, upper bits 0):
  - k=0 game_state
  - k=1 ball_x
  - k=2 ball_y
  - k=3 paddle1_y
  - k=4 paddle2_y
  - k=5 player_1_score
  - k=6 player_2_score
- States: IDLE, WRITE, DONE.
- IDLE: if update=1 in cycle N:
  - register a snapshot of all inputs at the N edge;
  - go to WRITE with counter=0.
- WRITE: registered outputs are we_a=1, addr_a=BASE_ADDR+counter, data_a=snapshot word[counter].
  - Words appear in cycles N+1 .. N+REC_WORDS.
  - Counter increments each cycle.
  - After word REC_WORDS-1, go to DONE.
- DONE: one cycle, at N+REC_WORDS+1. done=1, we_a=0.
  - If pending=1: take a fresh snapshot from the current inputs, clear pending, go to WRITE.
  - Otherwise go to IDLE.
- Latency: first write 1 cycle after the accepted update. Record occupies REC_WORDS cycles. done follows the last write by 1 cycle. Minimum spacing between records is REC_WORDS+1 cycles.
- update while busy: sets pending. Multiple requests coalesce into one; pending is one deep. An update arriving in the DONE cycle itself also sets or keeps pending.
- Snapshot isolation: input changes during WRITE must not alter the words being written.
- we_a=0 in IDLE and DONE. addr_a and data_a hold their last values when we_a=0.
- addr_a wraps modulo 2^16 if BASE_ADDR+k overflows.
- Reset mid-record: next cycle we_a=0, state=IDLE, pending=0. Remaining words are not written, so memory may hold a partial record. No done pulse is issued.
- update and reset asserted together: reset wins and the request is dropped.

Optional Feature:
- Macro: CHECKSUM_EN.
- Defined:
  - REC_WORDS=8.
  - Word k=7 at BASE_ADDR+7 is the bitwise XOR of snapshot words 0..6.
  - done follows the 8th write.
- Undefined:
  - REC_WORDS=7.
  - No word is written at BASE_ADDR+7.
  - No checksum logic is present.

Test Plan:
- Reset, then update pulse with game_state=2, ball_x=320, ball_y=240, paddle1_y=200, paddle2_y=180, p1=12, p2=7 -> cycles N+1..N+7 show we_a=1 with addr 0..6 and data 2, 320, 240, 200, 180, 12, 7; done=1 at N+8; busy low at N+9.
- Change ball_x to 100 at cycle N+3 of a record in progress -> word 1 is still 320; busy=1 throughout N+1..N+8.
- Three update pulses during WRITE -> exactly one additional record starts at the DONE cycle (first write at N+9), using the input values at N+8; then IDLE.
- Assert reset at N+4 -> we_a=0 from N+5 on, no done pulse, busy=0, pending cleared; a later update writes a complete record from addr 0.
- BASE_ADDR=16'hFFFC -> addresses FFFC, FFFD, FFFE, FFFF, 0000, 0001, 0002.
- CHECKSUM_EN defined, record 2, 320, 240, 200, 180, 12, 7 -> 8th write at addr 7 with data = XOR of those seven words; done at N+9.

Source files
------------

// File: rtl/fsm_write_data.sv
// Writes a snapshot of the game variables as a fixed block of 16-bit words into BRAM port A.
// Optional macro CHECKSUM_EN appends an XOR checksum word, making the record 8 words long.
module fsm_write_data #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        update,
  input  logic [1:0]  game_state,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  paddle1_y,
  input  logic [9:0]  paddle2_y,
  input  logic [6:0]  player_1_score,
  input  logic [6:0]  player_2_score,
  output logic [15:0] addr_a,
  output logic [15:0] data_a,
  output logic        we_a,
  output logic        busy,
  output logic        done
);

`ifdef CHECKSUM_EN
  localparam int REC_WORDS = 8;
`else
  localparam int REC_WORDS = 7;
`endif
  localparam logic [2:0] LAST = 3'(REC_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  typedef struct packed {
    logic [1:0] gs;
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] p1;
    logic [9:0] p2;
    logic [6:0] s1;
    logic [6:0] s2;
  } snap_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        pending, pending_nxt;
  logic        capture;
  snap_t       snap, live, src;
  logic        we_nxt;
  logic [15:0] addr_nxt, data_nxt;

  function automatic logic [15:0] rec_word(input snap_t s, input logic [2:0] k);
    case (k)
      3'd0:    rec_word = {14'b0, s.gs};
      3'd1:    rec_word = {6'b0, s.bx};
      3'd2:    rec_word = {6'b0, s.by};
      3'd3:    rec_word = {6'b0, s.p1};
      3'd4:    rec_word = {6'b0, s.p2};
      3'd5:    rec_word = {9'b0, s.s1};
      3'd6:    rec_word = {9'b0, s.s2};
`ifdef CHECKSUM_EN
      default: rec_word = {14'b0, s.gs} ^ {6'b0, s.bx} ^ {6'b0, s.by} ^ {6'b0, s.p1}
                        ^ {6'b0, s.p2} ^ {9'b0, s.s1} ^ {9'b0, s.s2};
`else
      default: rec_word = 16'h0000;
`endif
    endcase
  endfunction

  assign live = {game_state, ball_x, ball_y, paddle1_y, paddle2_y, player_1_score, player_2_score};
  // Word 0 of a new record is driven in the same edge the snapshot is taken.
  assign src  = capture ? live : snap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      pending <= 1'b0;
      snap    <= '0;
      we_a    <= 1'b0;
      addr_a  <= BASE_ADDR;
      data_a  <= 16'h0000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      if (capture) snap <= live;
      we_a    <= we_nxt;
      addr_a  <= addr_nxt;
      data_a  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    capture     = 1'b0;
    case (state)
      IDLE: if (update || pending) begin
        state_nxt   = WRITE;
        cnt_nxt     = 3'd0;
        capture     = 1'b1;
        pending_nxt = 1'b0;
      end
      WRITE: begin
        if (update) pending_nxt = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
        else             cnt_nxt   = cnt + 3'd1;
      end
      DONE: begin
        // A request landing in the DONE cycle stays queued for the following record.
        pending_nxt = update;
        if (pending) begin
          state_nxt = WRITE;
          cnt_nxt   = 3'd0;
          capture   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we_nxt   = (state_nxt == WRITE);
    addr_nxt = addr_a;
    data_nxt = data_a;
    if (we_nxt) begin
      addr_nxt = BASE_ADDR + 16'(cnt_nxt);
      data_nxt = rec_word(src, cnt_nxt);
    end
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule
